cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Host-side run controller at the far end of the processor top's control/result interface.
- Drives the processor's reset and sequences a program run.
- Watches `done` and captures the final 16-bit `out` value.
- Presents the final value to the host via a valid/ready handshake.
- Records every change of `out` during the run into a small trace FIFO for the host to drain.
- Sits between the host/testbench and the processor top.

Parameters:
DATA_W, 16, width of processor result bus
RST_CYCLES, 4, cycles processor reset is held at run start (>=1)
TIMEOUT_CYC, 4096, max RUN cycles without done before abort
CNT_W, 16, cycle counter width (must hold TIMEOUT_CYC)
TRACE_DEPTH, 8, trace FIFO entries (power of 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset of this block
start  in  1  pulse: begin a run (accepted in IDLE only)
cpu_reset  out  1  active-high reset to processor top
cpu_out  in  DATA_W  processor result bus
cpu_done  in  1  processor completion flag
busy  out  1  high in RST_HOLD, RUN, RESULT
result  out  DATA_W  captured final value
result_valid  out  1  final value available
result_ready  in  1  host accepts result
timeout  out  1  run ended by timeout (valid with result_valid)
cycle_count  out  CNT_W  RUN cycles elapsed in last/current run
trace_data  out  DATA_W  FIFO head
trace_valid  out  1  FIFO not empty
trace_ready  in  1  host pops head
trace_ovf  out  1  sticky: trace entry dropped this run

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cpu_reset=1; busy=0; result=0; result_valid=0; timeout=0; cycle_count=0; trace_ovf=0.
  - FIFO empty; last-value register cleared.
- States: IDLE, RST_HOLD, RUN, RESULT. All outputs are registered.
- IDLE:
  - cpu_reset=1.
  - start=1 -> RST_HOLD. In the same edge: clear hold counter, cycle_count, timeout, trace_ovf; flush FIFO.
- RST_HOLD:
  - cpu_reset=1 for exactly RST_CYCLES clocks, then RUN.
  - cpu_reset falls on entry to RUN.
- RUN (cpu_reset=0):
  - cpu_done=1 sampled -> RESULT; result<=cpu_out on that edge; timeout=0.
  - Else cycle_count increments.
  - If cycle_count==TIMEOUT_CYC-1 and cpu_done=0 -> RESULT with timeout=1 and result<=cpu_out; cycle_count ends at TIMEOUT_CYC.
  - Done and timeout in the same cycle: done wins, timeout=0.
- RESULT:
  - cpu_reset=1 (processor frozen).
  - result_valid=1; result and timeout held stable until result_ready=1.
  - On handshake -> IDLE; result_valid=0 next cycle. result and cycle_count keep their values.
- start outside IDLE is ignored.
- Trace:
  - In every RUN cycle, push cpu_out if it is the first RUN cycle or cpu_out != last pushed value.
  - The last-value register updates on every push attempt.
  - Pop when trace_valid && trace_ready; trace_data is the FIFO head, valid in any state.
  - Full with push and no pop: drop the entry, set trace_ovf (sticky until next start).
  - Full with simultaneous push and pop: both happen, no drop.
  - Empty with pop requested: no-op.
- Reset mid-run aborts immediately with all reset values; no result is emitted.

Decomposition:
- Package cpu_run_pkg holds:
  - state enum (IDLE, RST_HOLD, RUN, RESULT);
  - default constants for DATA_W, RST_CYCLES, TIMEOUT_CYC, TRACE_DEPTH;
  - a clog2-based pointer-width helper.
- Sub-module trace_fifo: synchronous FIFO with async active-low reset, sync flush, push/pop/full/empty, full+push+pop passthrough.
- The FSM and counters stay in cpu_run_ctrl.

Test Plan:
- Normal run: start; cpu_done=1 with cpu_out=16'h002A on the 11th RUN cycle -> cpu_reset high exactly 4 clocks after start accepted, result=16'h002A, result_valid=1, cycle_count=10, timeout=0.
- Backpressure: hold result_ready=0 for 5 cycles and pulse start -> result_valid stays 1, result stable, start ignored; result_ready=1 -> IDLE, busy=0 next cycle.
- Timeout: TIMEOUT_CYC=32, cpu_done held 0, cpu_out=16'h00FF -> after 32 RUN cycles result=16'h00FF, timeout=1, cycle_count=32.
- Trace dedup: cpu_out per RUN cycle 1,1,2,3,3,4 then done -> trace pops 1,2,3,4 in order, then trace_valid=0, trace_ovf=0.
- Overflow: depth 8, 10 distinct values, trace_ready=0 -> 8 entries (first 8 values), trace_ovf=1. Repeat with trace_ready=1 while full -> no drop, trace_ovf=0.
- Async reset mid-RUN: assert reset=0 between edges -> outputs reach reset values immediately (cpu_reset=1, busy=0, FIFO empty); the next start runs normally.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_pkg: shared types and defaults for the CPU run controller.
//   run_state_t      - controller FSM states
//   DEF_*            - default parameter values
//   ptr_w()          - index width for a storage of the given depth (min 1)
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RST_HOLD,
        RUN,
        RESULT
    } run_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TRACE_DEPTH = 8;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host/processor-facing signal bundle of cpu_run_ctrl.
//   start, result_ready, trace_ready     host -> controller
//   cpu_out, cpu_done                    processor -> controller
//   cpu_reset                            controller -> processor
//   busy, result, result_valid, timeout,
//   cycle_count, trace_data, trace_valid,
//   trace_ovf                            controller -> host
// master: environment side (host + processor); slave: the controller.
interface cpu_run_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              cpu_reset;
    logic [DATA_W-1:0] cpu_out;
    logic              cpu_done;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [DATA_W-1:0] trace_data;
    logic              trace_valid;
    logic              trace_ready;
    logic              trace_ovf;

    modport master (
        output start, cpu_out, cpu_done, result_ready, trace_ready,
        input  cpu_reset, busy, result, result_valid, timeout,
               cycle_count, trace_data, trace_valid, trace_ovf
    );

    modport slave (
        input  start, cpu_out, cpu_done, result_ready, trace_ready,
        output cpu_reset, busy, result, result_valid, timeout,
               cycle_count, trace_data, trace_valid, trace_ovf
    );
endinterface

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// trace_fifo: synchronous FIFO for the run trace.
//   clk, rst_n   clock, async active-low reset (empties the FIFO)
//   flush        sync clear of all entries
//   push, wdata  write request / data
//   pop          read request (ignored when empty)
//   rdata        head entry
//   full, empty  occupancy flags
//   drop         push rejected this cycle (full and no pop)
module trace_fifo
    import cpu_run_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_TRACE_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              drop
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host-side run controller for the processor top.
// Holds the processor in reset, releases it for a run, captures the final
// result on done (or on timeout) and offers it via valid/ready. Every change
// of the processor output during RUN is logged into a trace FIFO.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    cpu_run_ctrl_if.slave: start, cpu_reset, cpu_out, cpu_done, busy,
//          result/result_valid/result_ready, timeout, cycle_count,
//          trace_data/trace_valid/trace_ready, trace_ovf
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input logic           clk,
    input logic           reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int HW = ptr_w(RST_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    run_state_t        state, state_nxt;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [DATA_W-1:0] result_q, result_nxt;
    logic              timeout_q, timeout_nxt;
    logic              ovf_q, ovf_nxt;
    logic              cpu_reset_q, cpu_reset_nxt;
    logic              busy_q, busy_nxt;
    logic              valid_q, valid_nxt;
    logic [DATA_W-1:0] last_q;
    logic              flush;
    logic              push_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    // First RUN cycle is identified by the freshly cleared cycle counter.
    assign push_req = (state == RUN) && ((count_q == '0) || (bus.cpu_out != last_q));

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        count_nxt   = count_q;
        result_nxt  = result_q;
        timeout_nxt = timeout_q;
        ovf_nxt     = ovf_q;
        flush       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = RST_HOLD;
                    hold_nxt    = '0;
                    count_nxt   = '0;
                    timeout_nxt = 1'b0;
                    ovf_nxt     = 1'b0;
                    flush       = 1'b1;
                end
            end
            RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                if (bus.cpu_done) begin
                    state_nxt   = RESULT;
                    result_nxt  = bus.cpu_out;
                    timeout_nxt = 1'b0;
                end else begin
                    count_nxt = count_q + 1'b1;
                    if (count_q == RUN_LAST) begin
                        state_nxt   = RESULT;
                        result_nxt  = bus.cpu_out;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            RESULT: begin
                if (bus.result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Drops only occur in RUN, so they never race the clear on start.
        if (fifo_drop) begin
            ovf_nxt = 1'b1;
        end

        // Registered outputs are decoded from the next state.
        cpu_reset_nxt = (state_nxt != RUN);
        busy_nxt      = (state_nxt != IDLE);
        valid_nxt     = (state_nxt == RESULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            count_q     <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            ovf_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            count_q     <= count_nxt;
            result_q    <= result_nxt;
            timeout_q   <= timeout_nxt;
            ovf_q       <= ovf_nxt;
            cpu_reset_q <= cpu_reset_nxt;
            busy_q      <= busy_nxt;
            valid_q     <= valid_nxt;
            if (push_req) begin
                last_q <= bus.cpu_out;
            end
        end
    end

    trace_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (flush),
        .push  (push_req),
        .wdata (bus.cpu_out),
        .pop   (bus.trace_ready),
        .rdata (bus.trace_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = count_q;
    assign bus.trace_valid  = !fifo_empty;
    assign bus.trace_ovf    = ovf_q;

    // Full state is only observable through drops; kept as a named net for debug.
    logic unused_full;
    assign unused_full = fifo_full;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl with
// TIMEOUT_CYC=32 so the timeout path is reachable in a short run.
module tb_cpu_run_ctrl;
    localparam int DATA_W      = 16;
    localparam int CNT_W       = 16;
    localparam int RST_CYCLES  = 4;
    localparam int TIMEOUT_CYC = 32;
    localparam int TRACE_DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cpu_run_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if();

    cpu_run_ctrl #(
        .DATA_W      (DATA_W),
        .RST_CYCLES  (RST_CYCLES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then verify cpu_reset stays high for exactly RST_CYCLES clocks.
    task automatic start_run();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        check_val("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
        for (int i = 0; i < RST_CYCLES; i++) begin
            check_val("cpu_reset_hold", {31'd0, bus_if.cpu_reset}, 32'd1);
            tick();
        end
        check_val("cpu_reset_fall", {31'd0, bus_if.cpu_reset}, 32'd0);
    endtask

    task automatic run_cycle(input logic [15:0] val, input logic done);
        bus_if.cpu_out  = val;
        bus_if.cpu_done = done;
        tick();
        bus_if.cpu_done = 1'b0;
    endtask

    task automatic handshake();
        bus_if.result_ready = 1'b1;
        tick();
        bus_if.result_ready = 1'b0;
        check_val("valid_after_hs", {31'd0, bus_if.result_valid}, 32'd0);
        check_val("busy_after_hs", {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic drain_expect(input logic [15:0] first, input int n);
        bus_if.trace_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_val("trace_valid", {31'd0, bus_if.trace_valid}, 32'd1);
            check_val("trace_data", {16'd0, bus_if.trace_data}, {16'd0, first + 16'(i)});
            tick();
        end
        bus_if.trace_ready = 1'b0;
        check_val("trace_empty", {31'd0, bus_if.trace_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] dedup_vals [6];
        logic [15:0] dedup_exp [4];
        dedup_vals = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4};
        dedup_exp  = '{16'd1, 16'd2, 16'd3, 16'd4};
        n_checks = 0;
        n_errors = 0;
        bus_if.start        = 1'b0;
        bus_if.cpu_out      = '0;
        bus_if.cpu_done     = 1'b0;
        bus_if.result_ready = 1'b0;
        bus_if.trace_ready  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;

        // Reset state
        check_val("rst_cpu_reset", {31'd0, bus_if.cpu_reset}, 32'd1);
        check_val("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check_val("rst_result", {16'd0, bus_if.result}, 32'd0);
        check_val("rst_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check_val("rst_timeout", {31'd0, bus_if.timeout}, 32'd0);
        check_val("rst_count", {16'd0, bus_if.cycle_count}, 32'd0);
        check_val("rst_ovf", {31'd0, bus_if.trace_ovf}, 32'd0);
        check_val("rst_trace_valid", {31'd0, bus_if.trace_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Normal run: done on the 11th RUN cycle
        start_run();
        for (int i = 0; i < 10; i++) run_cycle(16'h0010, 1'b0);
        check_val("norm_valid_early", {31'd0, bus_if.result_valid}, 32'd0);
        run_cycle(16'h002A, 1'b1);
        check_val("norm_result", {16'd0, bus_if.result}, 32'h2A);
        check_val("norm_valid", {31'd0, bus_if.result_valid}, 32'd1);
        check_val("norm_count", {16'd0, bus_if.cycle_count}, 32'd10);
        check_val("norm_timeout", {31'd0, bus_if.timeout}, 32'd0);
        check_val("norm_cpu_reset", {31'd0, bus_if.cpu_reset}, 32'd1);

        // Backpressure with an ignored start pulse
        for (int i = 0; i < 5; i++) begin
            bus_if.start = (i == 2);
            tick();
            bus_if.start = 1'b0;
            check_val("bp_valid", {31'd0, bus_if.result_valid}, 32'd1);
            check_val("bp_result", {16'd0, bus_if.result}, 32'h2A);
            check_val("bp_busy", {31'd0, bus_if.busy}, 32'd1);
        end
        handshake();
        check_val("hs_result_kept", {16'd0, bus_if.result}, 32'h2A);
        check_val("hs_count_kept", {16'd0, bus_if.cycle_count}, 32'd10);
        tick();
        check_val("idle_stays", {31'd0, bus_if.busy}, 32'd0);

        // Timeout
        start_run();
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) run_cycle(16'h00FF, 1'b0);
        check_val("to_valid_early", {31'd0, bus_if.result_valid}, 32'd0);
        check_val("to_count_early", {16'd0, bus_if.cycle_count}, 32'd31);
        run_cycle(16'h00FF, 1'b0);
        check_val("to_valid", {31'd0, bus_if.result_valid}, 32'd1);
        check_val("to_result", {16'd0, bus_if.result}, 32'hFF);
        check_val("to_flag", {31'd0, bus_if.timeout}, 32'd1);
        check_val("to_count", {16'd0, bus_if.cycle_count}, 32'd32);
        handshake();

        // Trace dedup
        start_run();
        check_val("dd_timeout_clr", {31'd0, bus_if.timeout}, 32'd0);
        for (int i = 0; i < 6; i++) run_cycle(dedup_vals[i], 1'b0);
        run_cycle(16'd4, 1'b1);
        bus_if.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("dd_valid", {31'd0, bus_if.trace_valid}, 32'd1);
            check_val("dd_data", {16'd0, bus_if.trace_data}, {16'd0, dedup_exp[i]});
            tick();
        end
        bus_if.trace_ready = 1'b0;
        check_val("dd_empty", {31'd0, bus_if.trace_valid}, 32'd0);
        check_val("dd_ovf", {31'd0, bus_if.trace_ovf}, 32'd0);
        handshake();

        // Overflow: 10 distinct values into 8 entries
        start_run();
        for (int k = 1; k <= 10; k++) run_cycle(16'(k), (k == 10));
        check_val("ovf_set", {31'd0, bus_if.trace_ovf}, 32'd1);
        check_val("ovf_count", {16'd0, bus_if.cycle_count}, 32'd9);
        check_val("ovf_result", {16'd0, bus_if.result}, 32'd10);
        drain_expect(16'd1, 8);
        handshake();

        // Full with simultaneous push and pop: no drop
        start_run();
        check_val("ovf_cleared", {31'd0, bus_if.trace_ovf}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            bus_if.trace_ready = (k >= 9);
            if (k == 9) check_val("pp_head", {16'd0, bus_if.trace_data}, 32'd1);
            run_cycle(16'(k), (k == 10));
        end
        bus_if.trace_ready = 1'b0;
        check_val("pp_ovf", {31'd0, bus_if.trace_ovf}, 32'd0);
        drain_expect(16'd3, 8);
        handshake();

        // Async reset mid-RUN
        start_run();
        for (int i = 0; i < 3; i++) run_cycle(16'h0005, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check_val("ar_cpu_reset", {31'd0, bus_if.cpu_reset}, 32'd1);
        check_val("ar_busy", {31'd0, bus_if.busy}, 32'd0);
        check_val("ar_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check_val("ar_count", {16'd0, bus_if.cycle_count}, 32'd0);
        check_val("ar_result", {16'd0, bus_if.result}, 32'd0);
        check_val("ar_trace_valid", {31'd0, bus_if.trace_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_run();
        run_cycle(16'h0007, 1'b0);
        run_cycle(16'h0007, 1'b0);
        run_cycle(16'h0055, 1'b1);
        check_val("ar2_result", {16'd0, bus_if.result}, 32'h55);
        check_val("ar2_count", {16'd0, bus_if.cycle_count}, 32'd2);
        check_val("ar2_valid", {31'd0, bus_if.result_valid}, 32'd1);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
